mem_port_arbiter: RTL and testbench

- Shares the single unified memory port of the multicycle CPU between two requesters.
  - Port 0: the CPU control path (instruction fetch and load/store).
  - Port 1: the program loader / debug port.
- Arbitrates, latches the winning request, runs one memory transaction with a req/ack handshake, and returns completion plus read data to the owner.
- Includes an ack watchdog so a dead memory cannot hang the CPU forever.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the CPU's single memory port: picks a requester,
// runs one req/ack memory transaction for it and reports completion, with an ack watchdog.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int ROUND_ROBIN = 0,
  parameter int TO_CYCLES   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  localparam int CW = (TO_CYCLES < 1) ? 1 : $clog2(TO_CYCLES + 1);
  localparam logic [CW:0] TO_LIM = (CW + 1)'(TO_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state_reg, state_next;
  logic            last_owner_reg, last_owner_next;
  logic            owner_reg, owner_next;
  logic            mem_we_reg, mem_we_next;
  logic [AW-1:0]   mem_addr_reg, mem_addr_next;
  logic [DW-1:0]   mem_wdata_reg, mem_wdata_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1:0]      gnt_reg, gnt_next;
  logic [1:0]      done_reg, done_next;
  logic [1:0]      err_reg, err_next;
  logic [DW-1:0]   rdata_reg [2];
  logic [DW-1:0]   rdata_next [2];
  logic [CW:0]     cnt_inc;
  logic            timeout;
  logic            win;

  assign cnt_inc = {1'b0, cnt_reg} + (CW + 1)'(1);
  // cnt_reg holds ack-less cycles already spent; this cycle would make it TO_CYCLES
  assign timeout = (TO_CYCLES != 0) && (cnt_inc == TO_LIM);

  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    owner_next      = owner_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    cnt_next        = cnt_reg;
    gnt_next        = 2'b00;
    done_next       = 2'b00;
    err_next        = 2'b00;
    rdata_next[0]   = rdata_reg[0];
    rdata_next[1]   = rdata_reg[1];

    if (m0_req && m1_req) begin
      win = (ROUND_ROBIN != 0) ? ~last_owner_reg : 1'b0;
    end else begin
      win = m1_req;
    end

    case (state_reg)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_next     = ACCESS;
          owner_next     = win;
          mem_we_next    = win ? m1_we    : m0_we;
          mem_addr_next  = win ? m1_addr  : m0_addr;
          mem_wdata_next = win ? m1_wdata : m0_wdata;
          cnt_next       = '0;
          gnt_next[win]  = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_next           = IDLE;
          last_owner_next      = owner_reg;
          done_next[owner_reg] = 1'b1;
          if (!mem_we_reg) begin
            rdata_next[owner_reg] = mem_rdata;
          end
        end else if (timeout) begin
          state_next            = IDLE;
          last_owner_next       = owner_reg;
          done_next[owner_reg]  = 1'b1;
          err_next[owner_reg]   = 1'b1;
          rdata_next[owner_reg] = '0;
        end else begin
          cnt_next = cnt_inc[CW-1:0];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_owner_reg <= 1'b1;
      owner_reg      <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      cnt_reg        <= '0;
      gnt_reg        <= 2'b00;
      done_reg       <= 2'b00;
      err_reg        <= 2'b00;
      rdata_reg[0]   <= '0;
      rdata_reg[1]   <= '0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      owner_reg      <= owner_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      cnt_reg        <= cnt_next;
      gnt_reg        <= gnt_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      rdata_reg[0]   <= rdata_next[0];
      rdata_reg[1]   <= rdata_next[1];
    end
  end

  assign mem_req   = (state_reg == ACCESS);
  assign busy      = (state_reg == ACCESS);
  assign owner     = owner_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign m0_gnt    = gnt_reg[0];
  assign m1_gnt    = gnt_reg[1];
  assign m0_done   = done_reg[0];
  assign m1_done   = done_reg[1];
  assign m0_err    = err_reg[0];
  assign m1_err    = err_reg[1];
  assign m0_rdata  = rdata_reg[0];
  assign m1_rdata  = rdata_reg[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance share all inputs;
// directed vectors, corner sequences and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, mem_ack = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, mem_rdata = '0;

  logic          a_m0_gnt, a_m0_done, a_m0_err, a_m1_gnt, a_m1_done, a_m1_err;
  logic          a_mem_req, a_mem_we, a_owner, a_busy;
  logic [DW-1:0] a_m0_rdata, a_m1_rdata, a_mem_wdata;
  logic [AW-1:0] a_mem_addr;
  logic          b_m0_gnt, b_m0_done, b_m0_err, b_m1_gnt, b_m1_done, b_m1_err;
  logic          b_mem_req, b_mem_we, b_owner, b_busy;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_mem_wdata;
  logic [AW-1:0] b_mem_addr;

  mem_port_arbiter #(.AW(AW), .DW(DW), .ROUND_ROBIN(1), .TO_CYCLES(TO)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_done(a_m0_done), .m0_err(a_m0_err), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_done(a_m1_done), .m1_err(a_m1_err), .m1_rdata(a_m1_rdata),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .owner(a_owner), .busy(a_busy)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .ROUND_ROBIN(0), .TO_CYCLES(TO)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_done(b_m0_done), .m0_err(b_m0_err), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_done(b_m1_done), .m1_err(b_m1_err), .m1_rdata(b_m1_rdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .owner(b_owner), .busy(b_busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Directed single transactions on the round-robin instance
  typedef struct {
    logic          port;
    logic          we;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    int            ack_delay;   // mem_req cycle index carrying mem_ack; -1 = never
    logic [31:0]   mrdata;
    int            exp_cycles;  // cycles mem_req stays high
    logic          exp_err;
    logic [31:0]   exp_rdata;   // owner's rdata after done
  } vec_t;

  vec_t vecs[6];
  logic [31:0] exp_rd [2];

  // Transaction-level reference: per instance, the pending transaction and the port rdata registers
  logic        md_busy [2], md_owner [2], md_last [2], md_we [2];
  int          md_wait [2];
  logic [31:0] md_addr [2], md_wdata [2];
  logic [1:0]  md_gnt [2], md_done [2], md_err [2];
  logic [31:0] md_rd [2][2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      md_busy[k] = 0; md_owner[k] = 0; md_last[k] = 1; md_we[k] = 0; md_wait[k] = 0;
      md_addr[k] = '0; md_wdata[k] = '0; md_gnt[k] = '0; md_done[k] = '0; md_err[k] = '0;
      md_rd[k][0] = '0; md_rd[k][1] = '0;
    end
  endtask

  task automatic model_step(input int k, input bit rr);
    logic w;
    md_gnt[k] = '0; md_done[k] = '0; md_err[k] = '0;
    if (!md_busy[k]) begin
      if (m0_req || m1_req) begin
        if (m0_req && m1_req) w = rr ? ~md_last[k] : 1'b0;
        else w = m1_req;
        md_busy[k] = 1; md_owner[k] = w; md_wait[k] = 0;
        md_we[k] = w ? m1_we : m0_we;
        md_addr[k] = w ? m1_addr : m0_addr;
        md_wdata[k] = w ? m1_wdata : m0_wdata;
        md_gnt[k][w] = 1'b1;
      end
    end else if (mem_ack) begin
      md_done[k][md_owner[k]] = 1'b1;
      if (!md_we[k]) md_rd[k][md_owner[k]] = mem_rdata;
      md_busy[k] = 0; md_last[k] = md_owner[k];
    end else begin
      md_wait[k]++;
      if (md_wait[k] == TO) begin
        md_done[k][md_owner[k]] = 1'b1;
        md_err[k][md_owner[k]] = 1'b1;
        md_rd[k][md_owner[k]] = '0;
        md_busy[k] = 0; md_last[k] = md_owner[k];
      end
    end
  endtask

  function automatic logic [255:0] pack_exp(input int k);
    return {118'd0, md_gnt[k], md_done[k], md_err[k], md_rd[k][1], md_rd[k][0],
            md_busy[k], md_busy[k], md_owner[k], md_we[k], md_addr[k], md_wdata[k]};
  endfunction

  function automatic logic [255:0] pack_a();
    return {118'd0, a_m1_gnt, a_m0_gnt, a_m1_done, a_m0_done, a_m1_err, a_m0_err,
            a_m1_rdata, a_m0_rdata, a_mem_req, a_busy, a_owner, a_mem_we, a_mem_addr, a_mem_wdata};
  endfunction

  function automatic logic [255:0] pack_b();
    return {118'd0, b_m1_gnt, b_m0_gnt, b_m1_done, b_m0_done, b_m1_err, b_m0_err,
            b_m1_rdata, b_m0_rdata, b_mem_req, b_busy, b_owner, b_mem_we, b_mem_addr, b_mem_wdata};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; m0_req = 0; m1_req = 0; mem_ack = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    @(negedge clk);
    if (v.port) begin
      m1_req = 1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
    end else begin
      m0_req = 1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
    end
    @(posedge clk); #1;
    check("vec_gnt", {a_m1_gnt, a_m0_gnt}, v.port ? 2'b10 : 2'b01);
    check("vec_start", {a_mem_req, a_busy, a_owner}, {2'b11, v.port});
    cyc = 0;
    while (a_mem_req && cyc < 20) begin
      @(negedge clk);
      if (v.port) m1_req = 0; else m0_req = 0;
      check("vec_mem_stable", {a_mem_we, a_mem_addr, a_mem_wdata}, {v.we, v.addr, v.wdata});
      mem_ack = (cyc == v.ack_delay);
      mem_rdata = mem_ack ? v.mrdata : $urandom();
      @(posedge clk); #1;
      cyc++;
    end
    check("vec_cycles", 256'(cyc), 256'(v.exp_cycles));
    exp_rd[v.port] = v.exp_rdata;
    check("vec_done", {a_m1_done, a_m0_done, a_m1_err, a_m0_err, a_busy},
          {v.port ? 2'b10 : 2'b01, v.exp_err ? (v.port ? 2'b10 : 2'b01) : 2'b00, 1'b0});
    check("vec_rdata", {a_m1_rdata, a_m0_rdata}, {exp_rd[1], exp_rd[0]});
    @(negedge clk);
    mem_ack = 0;
    @(posedge clk); #1;
    check("vec_done_pulse", {a_m1_done, a_m0_done, a_m1_err, a_m0_err, a_m1_gnt, a_m0_gnt}, 6'd0);
    $display("[TB] vec %0d port %0d we %0d addr %08h cycles %0d err %0d rdata %08h",
             idx, v.port, v.we, v.addr, cyc, v.port ? a_m1_err : a_m0_err,
             v.port ? a_m1_rdata : a_m0_rdata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [3:0] ord_a, ord_b;
    int na, nb, both;

    vecs[0] = '{0, 0, 32'h40, 32'h0,    0,  32'hDEADBEEF, 1, 0, 32'hDEADBEEF};
    vecs[1] = '{1, 1, 32'h10, 32'h1234, 3,  32'hFFFF0000, 4, 0, 32'h0};
    vecs[2] = '{1, 0, 32'h14, 32'h0,    3,  32'hCAFE0001, 4, 0, 32'hCAFE0001};
    vecs[3] = '{0, 0, 32'h44, 32'h0,    -1, 32'h0,        4, 1, 32'h0};
    vecs[4] = '{1, 1, 32'h20, 32'h77,   1,  32'h12345678, 2, 0, 32'hCAFE0001};
    vecs[5] = '{0, 0, 32'h80, 32'h0,    2,  32'h0BADF00D, 3, 0, 32'h0BADF00D};
    exp_rd[0] = '0; exp_rd[1] = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset_rr", pack_a(), 256'd0);
    check("reset_fp", pack_b(), 256'd0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Contention: both ports request continuously, zero-wait memory
    do_reset();
    m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0; m0_addr = 32'hA0; m1_addr = 32'hB0;
    mem_ack = 1; mem_rdata = 32'h5A5A5A5A;
    ord_a = '0; ord_b = '0; na = 0; nb = 0; both = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (a_m0_gnt && a_m1_gnt) both++;
      if (b_m0_gnt && b_m1_gnt) both++;
      if ((a_m0_gnt || a_m1_gnt) && na < 4) begin ord_a[3 - na] = a_m1_gnt; na++; end
      if ((b_m0_gnt || b_m1_gnt) && nb < 4) begin ord_b[3 - nb] = b_m1_gnt; nb++; end
    end
    check("contention_grants", {8'(na), 8'(nb), 8'(both)}, {8'd4, 8'd4, 8'd0});
    check("contention_rr_order", ord_a, 4'b0101);
    check("contention_fp_order", ord_b, 4'b0000);
    $display("[TB] contention rr order %b fp order %b", ord_a, ord_b);
    @(negedge clk);
    m0_req = 0; m1_req = 0; mem_ack = 0;
    repeat (2) @(posedge clk);

    // Reset during a port 1 access
    do_reset();
    m1_req = 1; m1_we = 0; m1_addr = 32'h99;
    @(posedge clk); #1;
    check("rst_mid_gnt", {a_m1_gnt, a_busy}, 2'b11);
    @(negedge clk);
    m1_req = 0;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("rst_mid_drop", {a_mem_req, a_busy, a_m1_gnt, a_m0_gnt, a_m1_done, a_m0_done}, 6'd0);
    @(negedge clk);
    m0_req = 1; m1_req = 1; mem_ack = 1;
    @(posedge clk); #1;
    check("rst_mid_no_done", {a_m1_done, a_m1_err, a_busy}, 3'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    check("rst_after_gnt", {a_m1_gnt, a_m0_gnt}, 2'b01);
    @(negedge clk);
    m0_req = 0; m1_req = 0;
    @(posedge clk); #1;
    check("rst_after_done", {a_m1_done, a_m0_done, a_m0_err}, 3'b010);
    $display("[TB] reset mid-access then port 0 served, done %0d", a_m0_done);
    @(negedge clk);
    mem_ack = 0;

    // Randomized run against the model, both instances
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      m0_req = ($urandom_range(0, 99) < 50);
      m1_req = ($urandom_range(0, 99) < 50);
      m0_we = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
      m0_addr = $urandom(); m1_addr = $urandom();
      m0_wdata = $urandom(); m1_wdata = $urandom();
      mem_ack = ($urandom_range(0, 99) < 30);
      mem_rdata = $urandom();
      @(posedge clk);
      model_step(0, 1'b1);
      model_step(1, 1'b0);
      #1;
      check("rand_rr", pack_a(), pack_exp(0));
      check("rand_fp", pack_b(), pack_exp(1));
      if (md_done[0] != 2'b00)
        $display("[TB] rand cycle %0d rr done port %0d err %0d", c, md_done[0][1], |md_err[0]);
      @(negedge clk);
    end
    m0_req = 0; m1_req = 0; mem_ack = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
